// File: rtl/keystream_gen_pkg.sv
// Shared types and the generator step function for the keystream engine.
package keystream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ks_state_t;

   localparam logic KS_MODE_LFSR = 1'b0;
   localparam logic KS_MODE_CNT  = 1'b1;

   // Widest supported word; callers zero-extend in and truncate out to W bits,
   // so the counter wraps modulo 2^W and the LFSR shift brings in zeros.
   localparam int KS_MAX_W = 64;

   function automatic logic [KS_MAX_W-1:0] ks_step(
      input logic [KS_MAX_W-1:0] gen,
      input logic                mode,
      input logic [KS_MAX_W-1:0] poly
   );
      if (mode == KS_MODE_CNT) begin
         return gen + KS_MAX_W'(1);
      end
      return (gen >> 1) ^ (gen[0] ? poly : '0);
   endfunction

endpackage

// File: rtl/keystream_gen_if.sv
// Method-style start/next handshake bundle of the keystream engine.
// Handshake: a method fires on a rising clock edge when its EN_* and RDY_* are both 1; EN_* with RDY_*=0 is ignored.
interface keystream_gen_if
   import keystream_pkg::*;
#(
   parameter int W      = 8,
   parameter int NWORDS = 16
);
   localparam int PW = $clog2(NWORDS + 1);

   logic          EN_start;
   logic [W-1:0]  start_seed;
   logic          start_mode;
   logic          RDY_start;
   logic          EN_next;
   logic [W-1:0]  next_k;
   logic [W-1:0]  next;
   logic          RDY_next;
   logic          busy;
   logic [PW-1:0] produced;
   ks_state_t     dbg_state;

   modport master (
      output EN_start, start_seed, start_mode, EN_next, next_k,
      input  RDY_start, RDY_next, next, busy, produced, dbg_state
   );

   modport slave (
      input  EN_start, start_seed, start_mode, EN_next, next_k,
      output RDY_start, RDY_next, next, busy, produced, dbg_state
   );

endinterface

// File: rtl/keystream_gen_fifo.sv
// Synchronous FIFO holding generated words; head is registered storage, reset to zero.
module ks_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [W-1:0]           data_i,
   input  logic                   pop_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [W-1:0]           head_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rptr_q, wptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/keystream_gen.sv
// Keystream engine: start loads seed/mode, RUN pushes NWORDS words, next pops head ^ next_k.
module keystream_gen
   import keystream_pkg::*;
#(
   parameter int           W      = 8,
   parameter int           DEPTH  = 4,
   parameter int           NWORDS = 16,
   parameter logic [W-1:0] POLY   = 8'hB8
) (
   input logic            CLK,
   input logic            RST,
   keystream_gen_if.slave bus
);
   localparam int PW = $clog2(NWORDS + 1);
   localparam int CW = $clog2(DEPTH) + 1;

   ks_state_t     state_q, state_d;
   logic [W-1:0]  gen_q, gen_d;
   logic          mode_q, mode_d;
   logic [PW-1:0] produced_q, produced_d;

   logic          fifo_full, fifo_empty;
   logic [W-1:0]  fifo_head;
   logic [CW-1:0] fifo_count;
   logic          start_acc, push, pop, last_push;

   assign start_acc = bus.EN_start && (state_q == IDLE);
   assign pop       = bus.EN_next && !fifo_empty;
   assign push      = (state_q == RUN) && !fifo_full;
   assign last_push = push && (produced_q == PW'(NWORDS - 1));

   ks_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (push),
      .data_i  (gen_q),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      gen_d      = gen_q;
      mode_d     = mode_q;
      produced_d = produced_q;
      case (state_q)
         IDLE: begin
            if (start_acc) begin
               state_d    = RUN;
               mode_d     = bus.start_mode;
               produced_d = '0;
               // An all-zero LFSR state would lock up, so substitute all-ones.
               if (bus.start_mode == KS_MODE_LFSR && bus.start_seed == '0) begin
                  gen_d = '1;
               end else begin
                  gen_d = bus.start_seed;
               end
            end
         end
         RUN: begin
            if (push) begin
               produced_d = produced_q + PW'(1);
               gen_d      = W'(ks_step(KS_MAX_W'(gen_q), mode_q, KS_MAX_W'(POLY)));
            end
            if (last_push) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty || (pop && fifo_count == CW'(1))) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         gen_q      <= '0;
         mode_q     <= KS_MODE_LFSR;
         produced_q <= '0;
      end else begin
         state_q    <= state_d;
         gen_q      <= gen_d;
         mode_q     <= mode_d;
         produced_q <= produced_d;
      end
   end

   assign bus.RDY_start = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.RDY_next  = !fifo_empty;
   assign bus.next      = fifo_head ^ bus.next_k;
   assign bus.produced  = produced_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_keystream_gen.sv
// Directed bench for keystream_gen: session model in a queue, per-pop compare, literal pins.
module tb_keystream_gen;
   import keystream_pkg::*;

   localparam int           W      = 8;
   localparam int           DEPTH  = 4;
   localparam int           NWORDS = 16;
   localparam logic [W-1:0] POLY   = 8'hB8;

   logic CLK = 1'b0;
   logic RST;

   keystream_gen_if #(.W(W), .NWORDS(NWORDS)) bus ();

   keystream_gen #(
      .W      (W),
      .DEPTH  (DEPTH),
      .NWORDS (NWORDS),
      .POLY   (POLY)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   logic [W-1:0] exp_q[$];
   int vectors = 0;
   int errors  = 0;
   int pop_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected words of one session, straight from the seed/mode rules.
   function automatic void model_session(input logic [W-1:0] seed, input logic mode);
      logic [W-1:0] g;
      g = (mode == KS_MODE_LFSR && seed == '0) ? {W{1'b1}} : seed;
      for (int i = 0; i < NWORDS; i++) begin
         exp_q.push_back(g);
         if (mode == KS_MODE_CNT) g = g + W'(1);
         else                     g = (g >> 1) ^ (g[0] ? POLY : '0);
      end
   endfunction

   always @(negedge CLK) begin
      if (!RST && bus.EN_next && bus.RDY_next) begin
         pop_cnt++;
         if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL extra_pop: got word %0h, expected no word available", bus.next);
         end else begin
            check("next_word", 32'(bus.next), 32'(exp_q.pop_front() ^ bus.next_k));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] seed, input logic mode);
      bus.start_seed = seed;
      bus.start_mode = mode;
      bus.EN_start   = 1'b1;
      tick();
      bus.EN_start   = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(bus.RDY_start && exp_q.size() == 0) && n < 100) begin
         tick();
         n++;
      end
      check({name, "_rdy_start"}, 32'(bus.RDY_start), 32'd1);
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      RST            = 1'b1;
      bus.EN_start   = 1'b0;
      bus.start_seed = '0;
      bus.start_mode = 1'b0;
      bus.EN_next    = 1'b0;
      bus.next_k     = 8'h5A;
      tick();
      tick();
      RST = 1'b0;
      check("rst_rdy_start", 32'(bus.RDY_start), 32'd1);
      check("rst_rdy_next",  32'(bus.RDY_next),  32'd0);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_produced",  32'(bus.produced),  32'd0);
      check("rst_next",      32'(bus.next),      32'h5A);

      // LFSR seed 01, continuous consumer; EN_next while empty first
      model_session(8'h01, KS_MODE_LFSR);
      check("pin_lfsr0", 32'(exp_q[0]), 32'h01);
      check("pin_lfsr1", 32'(exp_q[1]), 32'hB8);
      check("pin_lfsr2", 32'(exp_q[2]), 32'h5C);
      check("pin_lfsr3", 32'(exp_q[3]), 32'h2E);
      check("pin_lfsr4", 32'(exp_q[4]), 32'h17);
      check("pin_lfsr5", 32'(exp_q[5]), 32'hB3);
      bus.next_k  = 8'h00;
      bus.EN_next = 1'b1;
      repeat (3) tick();
      check("idle_rdy_next", 32'(bus.RDY_next), 32'd0);
      pop_cnt = 0;
      do_start(8'h01, KS_MODE_LFSR);
      check("lfsr_rdy_next_t1", 32'(bus.RDY_next), 32'd0);
      check("lfsr_busy", 32'(bus.busy), 32'd1);
      tick();
      check("lfsr_rdy_next_t2", 32'(bus.RDY_next), 32'd1);
      wait_done("lfsr");
      check("lfsr_pops", 32'(pop_cnt), 32'd16);
      check("lfsr_produced", 32'(bus.produced), 32'd16);

      // Counter wrap with XOR key
      model_session(8'hFE, KS_MODE_CNT);
      check("pin_cnt0", 32'(exp_q[0] ^ 8'h0F), 32'hF1);
      check("pin_cnt1", 32'(exp_q[1] ^ 8'h0F), 32'hF0);
      check("pin_cnt2", 32'(exp_q[2] ^ 8'h0F), 32'h0F);
      check("pin_cnt3", 32'(exp_q[3] ^ 8'h0F), 32'h0E);
      bus.next_k = 8'h0F;
      pop_cnt = 0;
      do_start(8'hFE, KS_MODE_CNT);
      wait_done("cnt");
      check("cnt_pops", 32'(pop_cnt), 32'd16);

      // Zero seeds
      bus.next_k = 8'hA5;
      model_session(8'h00, KS_MODE_LFSR);
      check("pin_zero_lfsr", 32'(exp_q[0]), 32'hFF);
      do_start(8'h00, KS_MODE_LFSR);
      wait_done("zero_lfsr");
      model_session(8'h00, KS_MODE_CNT);
      check("pin_zero_cnt", 32'(exp_q[0]), 32'h00);
      do_start(8'h00, KS_MODE_CNT);
      wait_done("zero_cnt");

      // Backpressure: buffer fills to DEPTH and stalls without overwrite
      bus.EN_next = 1'b0;
      bus.next_k  = 8'h3C;
      model_session(8'h3C, KS_MODE_LFSR);
      do_start(8'h3C, KS_MODE_LFSR);
      repeat (10) tick();
      check("bp_produced", 32'(bus.produced), 32'd4);
      check("bp_rdy_next", 32'(bus.RDY_next), 32'd1);
      check("bp_busy",     32'(bus.busy),     32'd1);
      pop_cnt     = 0;
      bus.EN_next = 1'b1;
      wait_done("bp");
      check("bp_pops", 32'(pop_cnt), 32'd16);

      // EN_start during RUN must not disturb the running sequence
      bus.next_k = 8'h00;
      pop_cnt    = 0;
      model_session(8'h81, KS_MODE_LFSR);
      do_start(8'h81, KS_MODE_LFSR);
      repeat (3) tick();
      bus.start_seed = 8'h55;
      bus.start_mode = KS_MODE_CNT;
      bus.EN_start   = 1'b1;
      tick();
      bus.EN_start   = 1'b0;
      check("ill_start_busy", 32'(bus.busy), 32'd1);
      wait_done("ill_start");
      check("ill_start_pops", 32'(pop_cnt), 32'd16);

      // EN_start together with the pop of the last word: accepted one cycle later
      pop_cnt = 0;
      model_session(8'h07, KS_MODE_CNT);
      do_start(8'h07, KS_MODE_CNT);
      for (int n = 0; n < 100; n++) begin
         if (exp_q.size() == 1 && bus.produced == 5'd16 && bus.RDY_next) break;
         tick();
      end
      check("last_left", 32'(exp_q.size()), 32'd1);
      model_session(8'h30, KS_MODE_CNT);
      bus.start_seed = 8'h30;
      bus.start_mode = KS_MODE_CNT;
      bus.EN_start   = 1'b1;
      tick();
      check("last_busy",      32'(bus.busy),      32'd0);
      check("last_rdy_start", 32'(bus.RDY_start), 32'd1);
      check("last_rdy_next",  32'(bus.RDY_next),  32'd0);
      tick();
      bus.EN_start = 1'b0;
      check("late_busy",     32'(bus.busy),     32'd1);
      check("late_produced", 32'(bus.produced), 32'd0);
      wait_done("late");
      check("late_pops", 32'(pop_cnt), 32'd32);

      // Reset mid-session with 3 words buffered
      bus.EN_next = 1'b0;
      bus.next_k  = 8'h33;
      do_start(8'h01, KS_MODE_LFSR);
      repeat (3) tick();
      check("mid_produced", 32'(bus.produced), 32'd3);
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      check("mid_rst_rdy_start", 32'(bus.RDY_start), 32'd1);
      check("mid_rst_rdy_next",  32'(bus.RDY_next),  32'd0);
      check("mid_rst_busy",      32'(bus.busy),      32'd0);
      check("mid_rst_produced",  32'(bus.produced),  32'd0);
      check("mid_rst_next",      32'(bus.next),      32'h33);

      // Fresh session after the reset
      bus.next_k  = 8'h00;
      bus.EN_next = 1'b1;
      pop_cnt     = 0;
      model_session(8'h01, KS_MODE_LFSR);
      do_start(8'h01, KS_MODE_LFSR);
      wait_done("post_rst");
      check("post_rst_pops", 32'(pop_cnt), 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
